regs_access_arbiter: RTL
========================

REGS_ACCESS_ARBITER -- requirements
Module: regs_access_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 4, the number of implemented registers downstream.
REQ-002 The block SHALL have parameter RD_LAT, default 1, the downstream read latency in cycles (1..3).
REQ-003 The block SHALL have these ports:
- clk  in  1  clock; one clock only.
- resetb  in  1  reset, asynchronous, active-low.
REQ-004 Requester A ports SHALL be:
- a_req  in  1  request.
- a_wr  in  1  1 = write, 0 = read.
- a_addr  in  4  address.
- a_wdata  in  8  write data.
- a_gnt  out  1  granted.
- a_done  out  1  completion pulse.
- a_err  out  1  error, qualified by a_done.
- a_rdata  out  8  read data.
REQ-005 Requester B ports SHALL mirror REQ-004 with the b_ prefix.
REQ-006 Register-block side ports SHALL be:
- address  out  4
- write_en  out  1
- read_en  out  1
- data_in  out  8
- read_data  in  8

Function
REQ-007 The FSM SHALL have states IDLE, ISSUE, WAIT_RD and DONE.
REQ-008 In IDLE with any req high, the block SHALL select one requester, latch its wr/addr/wdata and go to ISSUE next cycle.
REQ-009 Arbitration SHALL be round-robin: when both requests are high, the requester not served last wins; a lone request always wins.
REQ-010 The grant SHALL be held from ISSUE through DONE inclusive; gnt SHALL be low in IDLE.
REQ-011 ISSUE SHALL last exactly one cycle and drive address/data_in from the latched values.
REQ-012 In ISSUE, a write SHALL drive write_en=1, a read SHALL drive read_en=1, never both.
REQ-013 A write SHALL go from ISSUE to DONE.
REQ-014 A read SHALL go from ISSUE to WAIT_RD.
REQ-015 WAIT_RD SHALL last RD_LAT cycles, counted by a 2-bit down-counter.
REQ-016 On the last WAIT_RD cycle, the block SHALL capture read_data into the granted requester's rdata, then go to DONE.
REQ-017 DONE SHALL pulse the granted requester's done for exactly one cycle, update the last-served pointer and return to IDLE.
REQ-018 Latency from req first seen in IDLE to done SHALL be 2 cycles for a write and 2+RD_LAT cycles for a read.
REQ-019 If the latched addr is >= NUM_REGS, ISSUE SHALL assert neither enable, the FSM SHALL go to DONE, err SHALL be 1 with done, and rdata SHALL be 0x00.
REQ-020 Command inputs SHALL be sampled only in IDLE; changes to req/wr/addr/wdata after the grant SHALL be ignored.
REQ-021 Dropping req after the grant SHALL NOT abort the transaction.
REQ-022 A req still high in the IDLE cycle after DONE SHALL be treated as a new request.
REQ-023 The non-granted requester's rdata SHALL hold its previous value.
REQ-024 Outside ISSUE, write_en and read_en SHALL be 0; address and data_in SHALL hold the last latched values.
REQ-025 Back-to-back traffic SHALL reach at most one transaction per 3 cycles (write) and per 3+RD_LAT cycles (read).

Reset
REQ-026 While resetb=0, the state SHALL be IDLE.
REQ-027 While resetb=0, all gnt/done/err/enable outputs SHALL be 0, and rdata, address and data_in SHALL be 0x0.
REQ-028 On reset, the last-served pointer SHALL be B, so A wins the first contention.
REQ-029 Reset asserted mid-transaction SHALL abandon it with no done pulse; enables SHALL drop immediately.

Structure
REQ-030 A shared package regs_arb_pkg SHALL hold:
- the state enum;
- ADDR_W=4 and DATA_W=8;
- the requester-index type.
REQ-031 The 2-way round-robin picker SHALL be a sub-module regs_arb_rr with inputs req[1:0] and last and output sel.

Verification
REQ-032 Single write: A writes addr 2, data 0x5A. Required: write_en=1 for 1 cycle with address=2, data_in=0x5A; a_done 2 cycles after req; a_err=0.
REQ-033 Single read: B reads addr 2 after REQ-032, RD_LAT=1. Required: read_en=1 for 1 cycle; b_rdata=0x5A with b_done 3 cycles after req.
REQ-034 Contention: A and B request in the same cycle after reset, then both re-request. Required: A served first, B second, then A.
REQ-035 Bad address: A reads addr 7 with NUM_REGS=4. Required: no enable; a_done with a_err=1 and a_rdata=0x00 after 2 cycles.
REQ-036 Reset mid-read: resetb=0 during WAIT_RD. Required: no done pulse, all outputs 0; after release, A wins the first contention.
REQ-037 Input change after grant: A changes addr to 3 and drops req during ISSUE. Required: the original addr is used and a_done still pulses.

Source files
------------

// File: rtl/regs_arb_pkg.sv
// Shared types and helpers for the two-requester register access arbiter.
package regs_arb_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } arb_state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_idx_e;

  function automatic logic [1:0] idx_onehot(input req_idx_e idx);
    return (idx == REQ_B) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input int unsigned       num_regs);
    return ({{(32-ADDR_W){1'b0}}, addr} < num_regs);
  endfunction

endpackage

// File: rtl/regs_arb_rr.sv
// Two-way round-robin picker: on contention the requester not served last wins.
module regs_arb_rr
  import regs_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_idx_e   last,
  output req_idx_e   sel
);

  always_comb begin
    sel = REQ_A;
    if (req == 2'b11) begin
      sel = (last == REQ_A) ? REQ_B : REQ_A;
    end else if (req[1]) begin
      sel = REQ_B;
    end
  end

endmodule

// File: rtl/regs_access_arbiter.sv
// Arbitrates two requesters onto a single register-block port, one transaction at a time.
//
// state   | meaning
// IDLE    | no transaction; sample requests and latch the winner's command
// ISSUE   | one cycle driving the register port (enable only if address valid)
// WAIT_RD | read in flight; down-counter runs to terminal count then captures read_data
// DONE    | one-cycle done/err pulse to the owner, round-robin pointer updated
module regs_access_arbiter
  import regs_arb_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              resetb,

  input  logic              a_req,
  input  logic              a_wr,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_done,
  output logic              a_err,
  output logic [DATA_W-1:0] a_rdata,

  input  logic              b_req,
  input  logic              b_wr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_done,
  output logic              b_err,
  output logic [DATA_W-1:0] b_rdata,

  output logic [ADDR_W-1:0] address,
  output logic              write_en,
  output logic              read_en,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] read_data
);

  localparam logic [1:0] RD_CNT_LOAD = 2'(RD_LAT - 1);

  arb_state_e        state_q, state_d;
  req_idx_e          owner_q, owner_d;
  req_idx_e          last_q, last_d;
  req_idx_e          sel;
  logic              wr_q, wr_d;
  logic              bad_q, bad_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic [1:0]        err_q, err_d;
  logic              wen_q, wen_d;
  logic              ren_q, ren_d;

  regs_arb_rr u_rr (
    .req  ({b_req, a_req}),
    .last (last_q),
    .sel  (sel)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    wr_d      = wr_q;
    bad_d     = bad_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;

    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          owner_d = sel;
          wr_d    = (sel == REQ_B) ? b_wr    : a_wr;
          addr_d  = (sel == REQ_B) ? b_addr  : a_addr;
          wdata_d = (sel == REQ_B) ? b_wdata : a_wdata;
          bad_d   = !addr_in_range(addr_d, NUM_REGS);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bad_q) begin
          // Out-of-range access completes with err and a zeroed rdata.
          if (owner_q == REQ_B) b_rdata_d = '0;
          else                  a_rdata_d = '0;
          state_d = DONE;
        end else if (wr_q) begin
          state_d = DONE;
        end else begin
          cnt_d   = RD_CNT_LOAD;
          state_d = WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (cnt_q == 2'd0) begin
          if (owner_q == REQ_B) b_rdata_d = read_data;
          else                  a_rdata_d = read_data;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      DONE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they align with the state cycle.
    gnt_d  = (state_d != IDLE) ? idx_onehot(owner_d) : 2'b00;
    done_d = (state_d == DONE) ? idx_onehot(owner_d) : 2'b00;
    err_d  = done_d & {2{bad_d}};
    wen_d  = (state_d == ISSUE) &&  wr_d && !bad_d;
    ren_d  = (state_d == ISSUE) && !wr_d && !bad_d;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q   <= IDLE;
      owner_q   <= REQ_A;
      last_q    <= REQ_B;
      wr_q      <= 1'b0;
      bad_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= '0;
      wen_q     <= 1'b0;
      ren_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      wr_q      <= wr_d;
      bad_q     <= bad_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      wen_q     <= wen_d;
      ren_q     <= ren_d;
    end
  end

  assign a_gnt    = gnt_q[0];
  assign b_gnt    = gnt_q[1];
  assign a_done   = done_q[0];
  assign b_done   = done_q[1];
  assign a_err    = err_q[0];
  assign b_err    = err_q[1];
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign address  = addr_q;
  assign data_in  = wdata_q;
  assign write_en = wen_q;
  assign read_en  = ren_q;

endmodule
